// File: rtl/stall_mem_responder_pkg.sv
// Shared definitions for the stall_mem_responder slice: FSM state and
// operation encodings plus the request-legality helper.
package stall_mem_responder_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_DONE   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Exactly one of rd/wr, word-aligned address.
  function automatic logic legal_req(input logic rd, input logic wr, input logic a0);
    return (rd ^ wr) & ~a0;
  endfunction

endpackage

// File: rtl/stall_mem_responder_if.sv
// Data-memory access bus between the memory stage (master) and the
// multi-cycle responder (slave).
interface stall_mem_responder_if;
  import stall_mem_responder_pkg::*;

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              stall;
  logic              err;

  modport master (
    output rd, wr, addr, data_in,
    input  data_out, done, stall, err
  );

  modport slave (
    input  rd, wr, addr, data_in,
    output data_out, done, stall, err
  );

endinterface

// File: rtl/stall_mem_responder_mem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word access, stalls the
// requester for LATENCY busy cycles, then pulses done with the read data.
module stall_mem_responder
  import stall_mem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  stall_mem_responder_if.slave  bus
);

  state_t            state_reg;
  op_t               op_reg;
  logic [AW-1:0]     index_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              done_reg;
  logic              err_reg;

  logic              req_legal;
  logic              req_any;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_addr_bits;

  assign req_legal = legal_req(bus.rd, bus.wr, bus.addr[0]);
  assign req_any   = bus.rd | bus.wr;

  // Upper address bits are deliberately ignored so the array aliases modulo DEPTH.
  assign unused_addr_bits = ^bus.addr;

  // The only write opportunity is the final BUSY edge, so an aborted or halted
  // access can never disturb the array.
  assign mem_we = (state_reg == ST_BUSY) && (cnt_reg == '0) && (op_reg == OP_WR);

  mem_array #(
    .AW (AW),
    .DW (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .index (index_reg),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_RD;
      index_reg    <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // done and data_out are single-cycle unless re-asserted below.
      done_reg     <= 1'b0;
      data_out_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (halt) begin
            state_reg <= ST_HALTED;
          end else if (req_legal) begin
            op_reg    <= bus.wr ? OP_WR : OP_RD;
            index_reg <= bus.addr[AW:1];
            wdata_reg <= bus.data_in;
            cnt_reg   <= CNT_W'(LATENCY - 1);
            state_reg <= ST_BUSY;
          end else if (req_any) begin
            err_reg <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            if (op_reg == OP_RD) begin
              data_out_reg <= mem_rdata;
            end
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        // The request is still visible here; returning to IDLE unconditionally
        // keeps it from retriggering.
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        ST_HALTED: begin
          state_reg <= ST_HALTED;
        end
        default: begin
          state_reg <= ST_IDLE;
          err_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.stall    = ((state_reg == ST_IDLE) & ~halt & req_legal) | (state_reg == ST_BUSY);
  assign bus.data_out = data_out_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_stall_mem_responder.sv
// Scoreboard bench for stall_mem_responder: accesses push expected read data,
// a negedge monitor pops and compares on every done pulse.
module tb_stall_mem_responder;
  import stall_mem_responder_pkg::*;

  localparam int LAT = 4;
  localparam int AW  = 10;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic halt = 1'b0;

  stall_mem_responder_if bus();

  stall_mem_responder #(
    .LATENCY (LAT),
    .AW      (AW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst && bus.done === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_done: got done with data %h, required no response", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          fails++;
          $display("[TB] FAIL response_data: got %h, required %h", bus.data_out, e);
        end else begin
          $display("[TB] response data_out=%h", bus.data_out);
        end
      end
    end
  end

  // One complete legal access; the request is held through DONE to prove no retrigger.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input string name);
    int sc;
    bit got;
    @(negedge clk);
    bus.rd      = ~w;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    exp_q.push_back(exp);
    $display("[TB] %s %s addr=%h data_in=%h", name, w ? "wr" : "rd", a, d);
    sc  = 0;
    got = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      #1;
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.stall === 1'b1) sc++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 16'(got), 16'd1);
    check({name, "_stall_cycles"}, 16'(sc), 16'(LAT + 1));
    check({name, "_stall_in_done"}, 16'(bus.stall), 16'd0);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    @(negedge clk);
    #1;
    check({name, "_done_after"}, 16'(bus.done), 16'd0);
    check({name, "_data_after"}, bus.data_out, 16'h0000);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({name, "_err"}, 16'(bus.err), 16'd0);
    check({name, "_done"}, 16'(bus.done), 16'd0);
    check({name, "_data"}, bus.data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int bad_stall;
    int bad_done;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_data_out", bus.data_out, 16'h0000);
    check("reset_done", 16'(bus.done), 16'd0);
    check("reset_err", 16'(bus.err), 16'd0);
    check("reset_stall", 16'(bus.stall), 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: write then read back
    access(1'b1, 16'h0010, 16'hBEEF, 16'h0000, "t1_wr");
    access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "t1_rd");

    // 2: misaligned read sets sticky err, no response
    @(negedge clk);
    bus.rd   = 1'b1;
    bus.addr = 16'h0011;
    $display("[TB] t2 rd misaligned addr=0011");
    #1;
    check("t2_stall", 16'(bus.stall), 16'd0);
    @(negedge clk);
    #1;
    check("t2_err", 16'(bus.err), 16'd1);
    check("t2_done", 16'(bus.done), 16'd0);
    bus.rd = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t2_err_sticky", 16'(bus.err), 16'd1);
    access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "t2_rd");
    check("t2_err_after_legal", 16'(bus.err), 16'd1);

    // 3: rd&wr together is rejected and does not write
    do_reset("t3_rst");
    access(1'b1, 16'h0020, 16'hA5A5, 16'h0000, "t3_wr");
    @(negedge clk);
    bus.rd      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 16'h0020;
    bus.data_in = 16'hFFFF;
    $display("[TB] t3 rd+wr addr=0020 data_in=ffff");
    #1;
    check("t3_stall", 16'(bus.stall), 16'd0);
    @(negedge clk);
    #1;
    check("t3_err", 16'(bus.err), 16'd1);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    access(1'b0, 16'h0020, 16'h0000, 16'hA5A5, "t3_rd");

    // 4: address alias modulo DEPTH
    access(1'b1, 16'h0804, 16'h1234, 16'h0000, "t4_wr");
    access(1'b0, 16'h0004, 16'h0000, 16'h1234, "t4_rd");

    // 5: reset during BUSY aborts the write
    access(1'b1, 16'h0030, 16'h5555, 16'h0000, "t5_wr");
    @(negedge clk);
    bus.wr      = 1'b1;
    bus.addr    = 16'h0030;
    bus.data_in = 16'hDEAD;
    $display("[TB] t5 wr addr=0030 data_in=dead (to be aborted)");
    repeat (3) @(negedge clk);
    #2;
    check("t5_busy_stall", 16'(bus.stall), 16'd1);
    rst    = 1'b0;
    bus.wr = 1'b0;
    #1;
    check("t5_rst_stall", 16'(bus.stall), 16'd0);
    check("t5_rst_done", 16'(bus.done), 16'd0);
    check("t5_rst_err", 16'(bus.err), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 16'h0030, 16'h0000, 16'h5555, "t5_rd");

    // 6: halt wins over a held read and is terminal
    @(negedge clk);
    halt     = 1'b1;
    bus.rd   = 1'b1;
    bus.addr = 16'h0010;
    $display("[TB] t6 halt with rd held addr=0010");
    #1;
    check("t6_stall_on_halt", 16'(bus.stall), 16'd0);
    @(negedge clk);
    halt      = 1'b0;
    bad_stall = 0;
    bad_done  = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.stall !== 1'b0) bad_stall++;
      if (bus.done !== 1'b0) bad_done++;
      @(negedge clk);
    end
    check("t6_halted_stall_cycles", 16'(bad_stall), 16'd0);
    check("t6_halted_done_cycles", 16'(bad_done), 16'd0);
    bus.rd = 1'b0;
    do_reset("t6_rst");
    access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, "t6_rd");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
